// File: rtl/lfsr_ctrl_if.sv
// Command channel into the LFSR sequencer: valid/ready handshake carrying an
// opcode (0=LOAD, 1=RUN, 2=STEP, 3=STOP) and an 8-bit argument.
interface lfsr_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_arg;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_arg,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_arg,
      output cmd_ready
   );
endinterface

// File: rtl/lfsr_ctrl.sv
// Sequencer for the 8-bit LFSR pattern datapath: load/run/step/stop commands,
// prescaled shift strobes and period measurement against the seed.
// Optional LFSR_CTRL_AUTOSTOP_EN: the first period detection in RUN ends the run.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a command
// S_LOAD | one cycle, lfsr_load strobe copies lfsr_seed into the LFSR
// S_RUN  | free-running shifts every DIV cycles until STOP
// S_STEP | issuing a fixed number of shifts
// S_DONE | step sequence (or auto-stopped run) finished, done=1
module lfsr_ctrl #(
   parameter int unsigned DIV   = 5000000,
   parameter int unsigned PER_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   lfsr_ctrl_if.slave       cmd,
   input  logic [7:0]       lfsr_q,
   output logic             lfsr_load,
   output logic [7:0]       lfsr_seed,
   output logic             lfsr_shift,
   output logic             busy,
   output logic             done,
   output logic [PER_W-1:0] period,
   output logic             period_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_STEP,
      S_DONE
   } state_t;

   localparam int unsigned      PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
   localparam logic [PER_W-1:0] PER_MAX = '1;

   localparam logic [1:0] OP_LOAD = 2'd0;
   localparam logic [1:0] OP_RUN  = 2'd1;
   localparam logic [1:0] OP_STEP = 2'd2;
   localparam logic [1:0] OP_STOP = 2'd3;

   state_t           state;
   state_t           state_nxt;
   logic [PRE_W-1:0] presc;
   logic [7:0]       step_cnt;
   logic [PER_W-1:0] per_cnt;
   logic             shift_d;
   logic             accept;
   logic             idle_like;
   logic             tick;
   logic             hit;
   logic             auto_stop;
   logic             is_load;
   logic             is_start;
   logic             is_step;

   assign cmd.cmd_ready = (state == S_IDLE) || (state == S_DONE) || (state == S_RUN);
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   assign idle_like     = (state == S_IDLE) || (state == S_DONE);

   // Commands other than STOP are swallowed while running.
   assign is_load  = accept && idle_like && (cmd.cmd_op == OP_LOAD);
   assign is_step  = accept && idle_like && (cmd.cmd_op == OP_STEP);
   assign is_start = accept && idle_like &&
                     ((cmd.cmd_op == OP_RUN) || ((cmd.cmd_op == OP_STEP) && (cmd.cmd_arg != 8'd0)));

   // lfsr_q already reflects the previous shift, so compare one cycle later.
   assign hit = shift_d && (lfsr_q == lfsr_seed);

`ifdef LFSR_CTRL_AUTOSTOP_EN
   assign auto_stop = hit && (state == S_RUN);
`else
   assign auto_stop = 1'b0;
`endif

   assign busy       = (state == S_RUN) || (state == S_STEP);
   assign done       = (state == S_DONE);
   assign lfsr_load  = (state == S_LOAD);
   assign tick       = busy && (presc == PRE_MAX) && !auto_stop;
   assign lfsr_shift = tick;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) begin
               case (cmd.cmd_op)
                  OP_LOAD: state_nxt = S_LOAD;
                  OP_RUN:  state_nxt = S_RUN;
                  OP_STEP: state_nxt = (cmd.cmd_arg == 8'd0) ? S_DONE : S_STEP;
                  default: state_nxt = S_IDLE;
               endcase
            end
         end
         S_LOAD: state_nxt = S_IDLE;
         S_RUN: begin
            if (accept && (cmd.cmd_op == OP_STOP)) begin
               state_nxt = S_IDLE;
            end else if (auto_stop) begin
               state_nxt = S_DONE;
            end
         end
         S_STEP: begin
            if (tick && (step_cnt == 8'd1)) begin
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_seed    <= 8'h01;
         presc        <= '0;
         step_cnt     <= 8'd0;
         per_cnt      <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         shift_d      <= 1'b0;
      end else begin
         shift_d <= tick;

         // An all-zero seed would lock the LFSR, so substitute 1.
         if (is_load) begin
            lfsr_seed <= (cmd.cmd_arg == 8'd0) ? 8'h01 : cmd.cmd_arg;
         end

         if (!busy || (presc == PRE_MAX)) begin
            presc <= '0;
         end else begin
            presc <= presc + 1'b1;
         end

         if (is_step) begin
            step_cnt <= cmd.cmd_arg;
         end else if ((state == S_STEP) && tick) begin
            step_cnt <= step_cnt - 8'd1;
         end

         // A shift coinciding with detection is the first of the next period.
         if (is_start || is_load) begin
            per_cnt <= '0;
         end else if (hit) begin
            per_cnt <= tick ? PER_W'(1) : '0;
         end else if (tick && (per_cnt != PER_MAX)) begin
            per_cnt <= per_cnt + 1'b1;
         end

         if (is_load) begin
            period_valid <= 1'b0;
         end else if (hit) begin
            period       <= per_cnt;
            period_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl with DIV=4 driving a right-shift LFSR model
// (bit7 <= q4^q3^q2^q0, period 255).
module tb_lfsr_ctrl;
   localparam int unsigned DIV   = 4;
   localparam int unsigned PER_W = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       lfsr_q = 8'h00;
   logic             lfsr_load;
   logic [7:0]       lfsr_seed;
   logic             lfsr_shift;
   logic             busy;
   logic             done;
   logic [PER_W-1:0] period;
   logic             period_valid;

   lfsr_ctrl_if cmd_bus ();

   lfsr_ctrl #(.DIV(DIV), .PER_W(PER_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd          (cmd_bus),
      .lfsr_q       (lfsr_q),
      .lfsr_load    (lfsr_load),
      .lfsr_seed    (lfsr_seed),
      .lfsr_shift   (lfsr_shift),
      .busy         (busy),
      .done         (done),
      .period       (period),
      .period_valid (period_valid)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int shift_cnt = 0;
   int shift_edge[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (lfsr_load) lfsr_q <= lfsr_seed;
      else if (lfsr_shift) lfsr_q <= {lfsr_q[4] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0], lfsr_q[7:1]};
   end

   always @(negedge clk) begin
      if (lfsr_shift === 1'b1) begin
         shift_cnt++;
         shift_edge.push_back(cyc + 1);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   int acc_cyc;

   task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
      int waited;
      waited = 0;
      @(negedge clk);
      while (cmd_bus.cmd_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) check("cmd_ready_timeout", 32'(cmd_bus.cmd_ready), 32'd1);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_arg   = arg;
      @(posedge clk);
      #1;
      cmd_bus.cmd_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   initial begin
      int base;
      int snap;
      int n;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_op    = 2'd0;
      cmd_bus.cmd_arg   = 8'd0;

      // 1: reset asserted mid-cycle
      #2 rst = 1'b0;
      #1;
      check("rst_seed", 32'(lfsr_seed), 32'h01);
      check("rst_load", 32'(lfsr_load), 32'd0);
      check("rst_shift", 32'(lfsr_shift), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_period", 32'(period), 32'd0);
      check("rst_pvalid", 32'(period_valid), 32'd0);
      check("rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // 2: LOAD A5, then LOAD 0 substitutes 01
      send_cmd(2'd0, 8'hA5);
      check("load_strobe", 32'(lfsr_load), 32'd1);
      check("load_seed", 32'(lfsr_seed), 32'hA5);
      check("load_ready", 32'(cmd_bus.cmd_ready), 32'd0);
      @(posedge clk); #1;
      check("load_strobe_end", 32'(lfsr_load), 32'd0);
      check("load_lfsr", 32'(lfsr_q), 32'hA5);
      send_cmd(2'd0, 8'h00);
      check("load_zero_seed", 32'(lfsr_seed), 32'h01);
      @(posedge clk); #1;
      check("load_zero_lfsr", 32'(lfsr_q), 32'h01);
      send_cmd(2'd0, 8'hA5);
      @(posedge clk); #1;

      // 3: STEP 3 from A5 -> 52, A9, 54
      base = shift_cnt;
      send_cmd(2'd2, 8'd3);
      check("step_ready", 32'(cmd_bus.cmd_ready), 32'd0);
      check("step_busy", 32'(busy), 32'd1);
      n = 0;
      while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      check("step_done", 32'(done), 32'd1);
      check("step_count", 32'(shift_cnt - base), 32'd3);
      if (shift_cnt - base >= 3) begin
         check("step_first_edge", 32'(shift_edge[base] - acc_cyc), 32'd4);
         check("step_second_edge", 32'(shift_edge[base+1] - acc_cyc), 32'd8);
         check("step_third_edge", 32'(shift_edge[base+2] - acc_cyc), 32'd12);
      end
      check("step_lfsr", 32'(lfsr_q), 32'h54);
      check("step_busy_end", 32'(busy), 32'd0);

      // 4: STOP from DONE, then STEP 0
      send_cmd(2'd3, 8'd0);
      check("stop_done_clr", 32'(done), 32'd0);
      base = shift_cnt;
      send_cmd(2'd2, 8'd0);
      check("step0_done", 32'(done), 32'd1);
      check("step0_busy", 32'(busy), 32'd0);
      repeat (8) @(negedge clk);
      check("step0_shifts", 32'(shift_cnt - base), 32'd0);
      check("step0_lfsr", 32'(lfsr_q), 32'h54);

      // 5: period measurement from seed 01
      send_cmd(2'd0, 8'h01);
      @(posedge clk); #1;
      check("run_seed_lfsr", 32'(lfsr_q), 32'h01);
      base = shift_cnt;
      send_cmd(2'd1, 8'd0);
      repeat (10) @(negedge clk);
      send_cmd(2'd0, 8'h33);
      check("run_load_ignored", 32'(lfsr_seed), 32'h01);
      check("run_load_busy", 32'(busy), 32'd1);
`ifdef LFSR_CTRL_AUTOSTOP_EN
      n = 0;
      while (done !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
      check("auto_done", 32'(done), 32'd1);
      check("auto_shifts", 32'(shift_cnt - base), 32'd255);
      check("auto_lfsr", 32'(lfsr_q), 32'h01);
      repeat (12) @(negedge clk);
      check("auto_no_more", 32'(shift_cnt - base), 32'd255);
`else
      repeat (1100) @(negedge clk);
      check("run_busy", 32'(busy), 32'd1);
      check("run_past_255", 32'(shift_cnt - base > 255), 32'd1);
`endif
      check("run_period", 32'(period), 32'd255);
      check("run_pvalid", 32'(period_valid), 32'd1);
      send_cmd(2'd3, 8'd0);
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_done", 32'(done), 32'd0);
      snap = shift_cnt;
      repeat (20) @(negedge clk);
      check("stop_no_shift", 32'(shift_cnt - snap), 32'd0);

      // LOAD clears period_valid but keeps the last period
      send_cmd(2'd0, 8'h01);
      check("reload_pvalid", 32'(period_valid), 32'd0);
      check("reload_period", 32'(period), 32'd255);

      // 6: reset mid-run
      send_cmd(2'd1, 8'd0);
      repeat (6) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_shift", 32'(lfsr_shift), 32'd0);
      check("midrst_seed", 32'(lfsr_seed), 32'h01);
      check("midrst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      snap = shift_cnt;
      repeat (6) @(negedge clk);
      check("midrst_no_shift", 32'(shift_cnt - snap), 32'd0);
      rst = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
